// File: rtl/pci_tx_pkg.sv
// Shared types and constants for the transmission-layer destination read path.
package pci_tx_pkg;

   localparam int unsigned DEST_BIT           = 4;
   localparam int unsigned DEFAULT_DATA_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

endpackage

// File: rtl/fifo_salida.sv
// Output buffer for lector_destinos: wrap-around pointers, occupancy count,
// first-word-fall-through head.
module fifo_salida #(
   parameter int unsigned WIDTH = 7,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   occ
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en && !reset)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   occ <= occ + (AW+1)'(1);
            2'b01:   occ <= occ - (AW+1)'(1);
            default: occ <= occ;
         endcase
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/lector_destinos.sv
// Round-robin reader of destination FIFOs D0/D1 merging into one valid/ready stream.
// Optional destination tag check enabled by defining LECTOR_TAG_CHECK_EN.
module lector_destinos
   import pci_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned BUF_DEPTH  = 4,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] data_out_D0,
   input  logic [DATA_WIDTH-1:0] data_out_D1,
   input  logic                  empty_fifo_D0,
   input  logic                  empty_fifo_D1,
   output logic                  D0_pop,
   output logic                  D1_pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  src_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic [CNT_WIDTH-1:0]  count_D0,
   output logic [CNT_WIDTH-1:0]  count_D1,
   output logic                  idle_out
`ifdef LECTOR_TAG_CHECK_EN
   ,
   output logic                  error_dest
`endif
);

   localparam int unsigned OW = $clog2(BUF_DEPTH);

   state_t                state, state_nx;
   logic                  pend;
   logic                  pend_src;
   logic                  last;
   logic                  sel;
   logic                  can_pop;
   logic [OW:0]           occ;
   logic [OW+1:0]         used;
   logic [DATA_WIDTH-1:0] cap_data;
   logic [DATA_WIDTH:0]   head;

   // Credit counts the word already in flight from the FIFO so the buffer never overflows.
   assign used = {1'b0, occ} + (OW+2)'(pend);

   always_comb begin
      sel = 1'b0;
      if (!empty_fifo_D0 && !empty_fifo_D1)
         sel = ~last;
      else if (!empty_fifo_D1)
         sel = 1'b1;
      can_pop = (state == ACTIVE) && (used < (OW+2)'(BUF_DEPTH))
                && !(empty_fifo_D0 && empty_fifo_D1);
      D0_pop  = can_pop & ~sel;
      D1_pop  = can_pop & sel;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (enable) state_nx = ACTIVE;
         ACTIVE:  if (!enable) state_nx = DRAIN;
         DRAIN: begin
            if (enable)
               state_nx = ACTIVE;
            else if (!pend && occ == '0)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         pend     <= 1'b0;
         pend_src <= 1'b0;
         last     <= 1'b1;
         count_D0 <= '0;
         count_D1 <= '0;
         idle_out <= 1'b1;
      end else begin
         state    <= state_nx;
         pend     <= can_pop;
         if (can_pop) begin
            pend_src <= sel;
            last     <= sel;
         end
         if (pend && !pend_src)
            count_D0 <= count_D0 + CNT_WIDTH'(1);
         if (pend && pend_src)
            count_D1 <= count_D1 + CNT_WIDTH'(1);
         // Requiring IDLE in both current and next state drops the flag on the exit edge.
         idle_out <= (state == IDLE) && (state_nx == IDLE);
      end
   end

   assign cap_data = pend_src ? data_out_D1 : data_out_D0;

   fifo_salida #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (BUF_DEPTH)
   ) u_fifo_salida (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (pend),
      .wr_data ({pend_src, cap_data}),
      .rd_en   (valid_out & ready_in),
      .rd_data (head),
      .occ     (occ)
   );

   assign valid_out = (occ != '0);
   assign data_out  = valid_out ? head[DATA_WIDTH-1:0] : '0;
   assign src_out   = valid_out ? head[DATA_WIDTH] : 1'b0;

`ifdef LECTOR_TAG_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)
         error_dest <= 1'b0;
      else if (pend && (cap_data[DEST_BIT] != pend_src))
         error_dest <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_lector_destinos.sv
// Directed bench for lector_destinos with behavioural D0/D1 FIFO models.
module tb_lector_destinos;

   localparam int unsigned DW = 6;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [DW-1:0] data_out_D0 = '0;
   logic [DW-1:0] data_out_D1 = '0;
   logic          empty_fifo_D0 = 1'b1;
   logic          empty_fifo_D1 = 1'b1;
   logic          D0_pop, D1_pop;
   logic [DW-1:0] data_out;
   logic          src_out, valid_out;
   logic          ready_in;
   logic [CW-1:0] count_D0, count_D1;
   logic          idle_out;
`ifdef LECTOR_TAG_CHECK_EN
   logic          error_dest;
`endif

   always #5 clk = ~clk;

   lector_destinos #(
      .DATA_WIDTH (DW),
      .BUF_DEPTH  (4),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .data_out_D0   (data_out_D0),
      .data_out_D1   (data_out_D1),
      .empty_fifo_D0 (empty_fifo_D0),
      .empty_fifo_D1 (empty_fifo_D1),
      .D0_pop        (D0_pop),
      .D1_pop        (D1_pop),
      .data_out      (data_out),
      .src_out       (src_out),
      .valid_out     (valid_out),
      .ready_in      (ready_in),
      .count_D0      (count_D0),
      .count_D1      (count_D1),
      .idle_out      (idle_out)
`ifdef LECTOR_TAG_CHECK_EN
      ,
      .error_dest    (error_dest)
`endif
   );

   // Source FIFO models: registered read data and registered empty flags.
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic          push0 = 1'b0, push1 = 1'b0;
   logic [DW-1:0] push_data = '0;

   always @(posedge clk) begin
      if (D0_pop && q0.size() > 0) data_out_D0 <= q0.pop_front();
      if (D1_pop && q1.size() > 0) data_out_D1 <= q1.pop_front();
      if (push0) q0.push_back(push_data);
      if (push1) q1.push_back(push_data);
      empty_fifo_D0 <= (q0.size() == 0);
      empty_fifo_D1 <= (q1.size() == 0);
   end

   // Monitor: pops and accepted words, recorded at the edge where they take effect.
   int          cyc = 0;
   logic        pop_log[$];
   int          pop_cyc[$];
   logic [DW:0] out_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (D0_pop) begin pop_log.push_back(1'b0); pop_cyc.push_back(cyc); end
      if (D1_pop) begin pop_log.push_back(1'b1); pop_cyc.push_back(cyc); end
      if (valid_out && ready_in && !reset) out_q.push_back({src_out, data_out});
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic dest, input logic [DW-1:0] v);
      push_data = v;
      push0 = ~dest;
      push1 = dest;
      @(negedge clk);
      push0 = 1'b0;
      push1 = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (idle_out) break;
      end
      check(tag, idle_out, 1);
   endtask

   int pb, ob;
   logic [DW:0] exp_rr [4];

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      ready_in = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_d0_pop", D0_pop, 0);
      check("rst_d1_pop", D1_pop, 0);
      check("rst_data", data_out, 0);
      check("rst_src", src_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_cnt0", count_D0, 0);
      check("rst_cnt1", count_D1, 0);
      check("rst_idle", idle_out, 1);
      reset = 1'b0;
      @(negedge clk);

      // Round-robin
      ready_in = 1'b1;
      push(1'b0, 6'h05);
      push(1'b0, 6'h04);
      push(1'b1, 6'h16);
      push(1'b1, 6'h14);
      pb = pop_log.size();
      ob = out_q.size();
      enable = 1'b1;
      repeat (12) @(negedge clk);
      check("rr_pops", pop_log.size() - pb, 4);
      check("rr_pop0", pop_log[pb],   0);
      check("rr_pop1", pop_log[pb+1], 1);
      check("rr_pop2", pop_log[pb+2], 0);
      check("rr_pop3", pop_log[pb+3], 1);
      check("rr_b2b", pop_cyc[pb+3] - pop_cyc[pb], 3);
      exp_rr[0] = 7'h05; exp_rr[1] = 7'h56; exp_rr[2] = 7'h04; exp_rr[3] = 7'h54;
      check("rr_nout", out_q.size() - ob, 4);
      for (int i = 0; i < 4; i++) check($sformatf("rr_out%0d", i), out_q[ob+i], exp_rr[i]);
      check("rr_cnt0", count_D0, 2);
      check("rr_cnt1", count_D1, 2);
      enable = 1'b0;
      wait_idle("rr_idle");

      // Backpressure
      do_reset();
      ready_in = 1'b0;
      for (int i = 1; i <= 6; i++) push(1'b0, DW'(i));
      pb = pop_log.size();
      ob = out_q.size();
      enable = 1'b1;
      repeat (12) @(negedge clk);
      check("bp_pops_held", pop_log.size() - pb, 4);
      check("bp_no_pop", D0_pop, 0);
      check("bp_valid", valid_out, 1);
      check("bp_head", data_out, 6'h01);
      ready_in = 1'b1;
      repeat (15) @(negedge clk);
      check("bp_pops_all", pop_log.size() - pb, 6);
      check("bp_nout", out_q.size() - ob, 6);
      for (int i = 0; i < 6; i++) check($sformatf("bp_out%0d", i), out_q[ob+i], 7'(i + 1));
      check("bp_cnt0", count_D0, 6);
      check("bp_cnt1", count_D1, 0);
      enable = 1'b0;
      wait_idle("bp_idle");

      // Disable while words are buffered
      do_reset();
      ready_in = 1'b0;
      push(1'b0, 6'h07);
      push(1'b0, 6'h08);
      pb = pop_log.size();
      ob = out_q.size();
      enable = 1'b1;
      repeat (6) @(negedge clk);
      check("dis_pops", pop_log.size() - pb, 2);
      check("dis_valid", valid_out, 1);
      enable = 1'b0;
      repeat (4) @(negedge clk);
      check("dis_no_more_pops", pop_log.size() - pb, 2);
      check("dis_not_idle", idle_out, 0);
      check("dis_head", data_out, 6'h07);
      ready_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!valid_out) break;
      end
      check("dis_drained", valid_out, 0);
      check("dis_nout", out_q.size() - ob, 2);
      check("dis_out0", out_q[ob],   7'h07);
      check("dis_out1", out_q[ob+1], 7'h08);
      check("dis_idle_e0", idle_out, 0);
      @(negedge clk);
      check("dis_idle_e1", idle_out, 0);
      @(negedge clk);
      check("dis_idle_e2", idle_out, 1);

      // Reset the cycle after a pop
      do_reset();
      ready_in = 1'b1;
      push(1'b1, 6'h19);
      ob = out_q.size();
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (D1_pop) break;
      end
      check("rm_pop_seen", D1_pop, 1);
      @(negedge clk);
      reset  = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("rm_valid", valid_out, 0);
      check("rm_data", data_out, 0);
      check("rm_src", src_out, 0);
      check("rm_cnt1", count_D1, 0);
      check("rm_idle", idle_out, 1);
      check("rm_pop", {D0_pop, D1_pop}, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rm_lost_valid", valid_out, 0);
      check("rm_lost_cnt", count_D1, 0);
      check("rm_lost_nout", out_q.size() - ob, 0);

      // Counter wrap
      do_reset();
      ready_in = 1'b1;
      for (int i = 0; i < 256; i++) push(1'b1, 6'h10 | DW'(i % 16));
      pb = pop_log.size();
      ob = out_q.size();
      enable = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (pop_log.size() - pb >= 256) break;
      end
      enable = 1'b0;
      wait_idle("wr_idle");
      check("wr_pops", pop_log.size() - pb, 256);
      check("wr_nout", out_q.size() - ob, 256);
      check("wr_last", out_q[ob+255], 7'h5F);
      check("wr_cnt1", count_D1, 0);
      check("wr_cnt0", count_D0, 0);

`ifdef LECTOR_TAG_CHECK_EN
      // Destination tag mismatch
      do_reset();
      ready_in = 1'b0;
      check("tag_rst", error_dest, 0);
      push(1'b0, 6'h12);
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (D0_pop) break;
      end
      check("tag_pop_seen", D0_pop, 1);
      @(negedge clk);
      check("tag_err_early", error_dest, 0);
      @(negedge clk);
      check("tag_err_set", error_dest, 1);
      check("tag_valid", valid_out, 1);
      check("tag_data", data_out, 6'h12);
      check("tag_src", src_out, 0);
      ready_in = 1'b1;
      enable   = 1'b0;
      repeat (5) @(negedge clk);
      check("tag_err_sticky", error_dest, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lector_destinos.md
# lector_destinos

Read side of the destination FIFOs D0/D1 in the transmission-layer full logic. Drains both destination FIFOs with round-robin arbitration, merges their words into a single valid/ready stream toward the next stage, and keeps per-destination word counts. It generates `D0_pop`/`D1_pop` so the full-logic bench no longer drives them by hand.

## Interface
- `DATA_WIDTH`, 6: word width; equals the destination FIFO width.
- `BUF_DEPTH`, 4: output buffer entries; a power of two, minimum 4.
- `CNT_WIDTH`, 8: width of the per-destination word counters.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `enable` in 1: allows new pops while high.
- `data_out_D0` in DATA_WIDTH: D0 FIFO read data. Valid the cycle after `D0_pop`.
- `data_out_D1` in DATA_WIDTH: D1 FIFO read data. Valid the cycle after `D1_pop`.
- `empty_fifo_D0` in 1: D0 FIFO empty flag, registered.
- `empty_fifo_D1` in 1: D1 FIFO empty flag, registered.
- `D0_pop` out 1: pops D0; at most one of D0/D1 pops per cycle.
- `D1_pop` out 1: pops D1.
- `data_out` out DATA_WIDTH: merged output word.
- `src_out` out 1: source of `data_out`; 0 = D0, 1 = D1.
- `valid_out` out 1: `data_out` and `src_out` are valid.
- `ready_in` in 1: downstream accepts the word when it is high together with `valid_out`.
- `count_D0` out CNT_WIDTH: words popped from D0; wraps modulo 2^CNT_WIDTH.
- `count_D1` out CNT_WIDTH: words popped from D1; wraps the same way.
- `idle_out` out 1: high only in IDLE.
- `error_dest` out 1: sticky tag-mismatch flag. Present only with `LECTOR_TAG_CHECK_EN`.

## Operation
- **FSM states:** IDLE, ACTIVE, DRAIN. Reset state is IDLE.
  - IDLE → ACTIVE when `enable`=1.
  - ACTIVE → DRAIN when `enable`=0.
  - DRAIN → IDLE once nothing is in flight and the buffer is empty.
  - DRAIN → ACTIVE if `enable` returns to 1.
- **Pop rule (ACTIVE only):**
  - Pop when `pend + occ < BUF_DEPTH`. `pend` is 1 if a pop was issued in the previous cycle; `occ` is the buffer occupancy.
  - The selected FIFO must be non-empty.
  - No pops in IDLE or DRAIN.
- **Arbitration:**
  - Only one FIFO non-empty: pop that FIFO.
  - Both non-empty: pop the FIFO not served last.
  - The `last` pointer updates only on a pop. Its reset value is 1, so D0 wins the first tie.
- **Capture:**
  - The cycle after a pop, `{src, data}` is written to the output buffer.
  - The matching `count_Dx` increments in that same cycle.
- **Output:**
  - `valid_out` = `occ != 0`.
  - The head entry drives `data_out`/`src_out`.
  - Pop the head on `valid_out & ready_in`.
  - Capture and head pop in the same cycle leave `occ` unchanged.
- **Occupancy:** the credit rule guarantees the buffer never overflows. `BUF_DEPTH`≥3 sustains 1 word/cycle with `ready_in` held high.
- **Reset mid-operation:**
  - Buffer, `pend`, counters, `last` and `error_dest` are cleared; FSM goes to IDLE.
  - A word popped in the reset cycle is discarded and not counted.
- **Reset values:** `D0_pop`=0, `D1_pop`=0, `data_out`=0, `src_out`=0, `valid_out`=0, `count_D0`=0, `count_D1`=0, `idle_out`=1, `error_dest`=0.

## Timing
- Pops are combinational from registered state and the empty flags; no combinational path from `ready_in` to the pops.
- Latency with an empty buffer: pop in cycle N → `valid_out` high in cycle N+2.
- `valid_out`, `data_out` and `src_out` hold stable while `valid_out & !ready_in`.
- `idle_out` is registered: it rises one cycle after entering IDLE.

## Configuration
- `LECTOR_TAG_CHECK_EN` defined:
  - Each captured word is checked: `data[DEST_BIT]` must equal `src`.
  - A mismatch sets `error_dest` the cycle after capture; it holds until reset.
  - The word is still forwarded unchanged.
- Undefined: no check logic and no `error_dest` port.

## Structure
- **Package `pci_tx_pkg`:**
  - State enum IDLE/ACTIVE/DRAIN.
  - `DEST_BIT` = 4.
  - Default `DATA_WIDTH` = 6.
- **Sub-module `fifo_salida`:**
  - Synchronous output buffer of `BUF_DEPTH` × (DATA_WIDTH+1) bits.
  - Wrap-around read/write pointers, `occ` output, first-word-fall-through head.
  - Arbiter, FSM and counters stay in `lector_destinos`.

## Test plan
- **Round-robin:** D0 holds 0x05,0x04; D1 holds 0x16,0x14; `enable`=1, `ready_in`=1 → pops D0,D1,D0,D1 back-to-back; outputs 0x05/src0, 0x16/src1, 0x04/src0, 0x14/src1; counts 2/2.
- **Backpressure:** D0 holds 6 words, `ready_in`=0 → exactly 4 pops then `D0_pop`=0; raise `ready_in` → remaining 2 popped; order preserved; `count_D0`=6.
- **Disable while active:** drop `enable` with 2 words buffered → no further pops, the 2 words drain, `idle_out`=1 one cycle after reaching IDLE.
- **Reset mid-transfer:** assert `reset` in the cycle after a pop → all outputs at reset values next cycle; word lost; counts 0.
- **Counter wrap:** 256 pops from D1 → `count_D1` returns to 0.
- **Tag check (`LECTOR_TAG_CHECK_EN`):** D0 supplies 0x12 (bit4=1) → `error_dest`=1 one cycle after capture and stays 1; 0x12 still output with `src_out`=0.
